// File: rtl/ps2_poly_key_decoder_if.sv
// ps2_poly_key_decoder_if
//   Byte-stream link from the PS/2 byte receiver into ps2_poly_key_decoder.
//   scan_data   8  byte from the PS/2 receiver
//   scan_valid  1  single-cycle strobe, scan_data valid
//   master: the receiver side (drives the byte), slave: the decoder side.
interface ps2_poly_key_decoder_if;
  logic [7:0] scan_data;
  logic       scan_valid;

  modport master (output scan_data, output scan_valid);
  modport slave  (input  scan_data, input  scan_valid);
endinterface

// File: rtl/ps2_poly_key_decoder.sv
// ps2_poly_key_decoder
//   Converts PS/2 scan-code bytes into polyphonic synth control. Tracks the E0
//   (extended) and F0 (break) prefixes, maps the a..j note row onto up to
//   NUM_VOICES held voices, and keeps octave / ADSR-select state plus single
//   cycle parameter inc/dec strobes. Everything runs on CLOCK_50.
//
//   Ports
//     CLOCK_50      in   system clock
//     resetn        in   asynchronous active-low reset
//     scan          if   slave side of ps2_poly_key_decoder_if (scan_data/scan_valid)
//     voice_note    out  4 bits per voice, note 0..11 (C=0 .. B=11)
//     voice_gate    out  per-voice held flag
//     voice_strike  out  per-voice one-cycle note-on pulse
//     octave        out  current octave, saturating OCT_MIN..OCT_MAX
//     adsr_sel      out  0=vol 1=A 2=D 3=S 4=R
//     param_inc     out  one-cycle pulse on first make of key v (2A)
//     param_dec     out  one-cycle pulse on first make of key c (21)
//     voice_drop    out  one-cycle pulse, note make with no free voice
//     sustain_on    out  sustain latch
//
//   Build option: define PS2DEC_SUSTAIN_EN to enable the space-bar (29)
//   sustain toggle and per-voice pending-release state. Without it, 29 is
//   ignored and sustain_on is tied low.
module ps2_poly_key_decoder #(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned OCT_W       = 3,
  parameter int unsigned OCT_MIN     = 1,
  parameter int unsigned OCT_MAX     = 6,
  parameter int unsigned OCT_DEFAULT = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  ps2_poly_key_decoder_if.slave     scan,
  output logic [4*NUM_VOICES-1:0]   voice_note,
  output logic [NUM_VOICES-1:0]     voice_gate,
  output logic [NUM_VOICES-1:0]     voice_strike,
  output logic [OCT_W-1:0]          octave,
  output logic [2:0]                adsr_sel,
  output logic                      param_inc,
  output logic                      param_dec,
  output logic                      voice_drop,
  output logic                      sustain_on
);

  localparam logic [OCT_W-1:0] L_OCT_MIN = OCT_W'(OCT_MIN);
  localparam logic [OCT_W-1:0] L_OCT_MAX = OCT_W'(OCT_MAX);
  localparam logic [OCT_W-1:0] L_OCT_DEF = OCT_W'(OCT_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_do_make;
  logic   w_do_break;

  // Scan-code to note; MSB flags a note key.
  function automatic logic [4:0] f_note(input logic [7:0] b);
    case (b)
      8'h1C:   f_note = {1'b1, 4'd0};
      8'h1D:   f_note = {1'b1, 4'd1};
      8'h1B:   f_note = {1'b1, 4'd2};
      8'h24:   f_note = {1'b1, 4'd3};
      8'h23:   f_note = {1'b1, 4'd4};
      8'h2B:   f_note = {1'b1, 4'd5};
      8'h2C:   f_note = {1'b1, 4'd6};
      8'h34:   f_note = {1'b1, 4'd7};
      8'h35:   f_note = {1'b1, 4'd8};
      8'h33:   f_note = {1'b1, 4'd9};
      8'h3C:   f_note = {1'b1, 4'd10};
      8'h3B:   f_note = {1'b1, 4'd11};
      default: f_note = 5'd0;
    endcase
  endfunction

  logic       w_note_ok;
  logic [3:0] w_note_val;
  assign {w_note_ok, w_note_val} = f_note(scan.scan_data);

  logic w_key_dn, w_key_up, w_key_dec, w_key_inc;
  assign w_key_dn  = (scan.scan_data == 8'h1A);
  assign w_key_up  = (scan.scan_data == 8'h22);
  assign w_key_dec = (scan.scan_data == 8'h21);
  assign w_key_inc = (scan.scan_data == 8'h2A);

  // ---------------------------------------------------------------- prefix FSM
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_make   = 1'b0;
    w_do_break  = 1'b0;
    if (scan.scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (scan.scan_data == 8'hE0)      w_state_nxt = ST_EXT;
          else if (scan.scan_data == 8'hF0) w_state_nxt = ST_BRK;
          else                              w_do_make   = 1'b1;
        end
        ST_BRK: begin
          if (scan.scan_data == 8'hE0)      w_state_nxt = ST_EXT;
          else if (scan.scan_data == 8'hF0) w_state_nxt = ST_BRK;
          else begin
            w_do_break  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (scan.scan_data == 8'hF0) w_state_nxt = ST_EXT_BRK;
          else                         w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- voices
  logic [NUM_VOICES-1:0][3:0] r_note, w_note_nxt;
  logic [NUM_VOICES-1:0]      r_gate, w_gate_nxt;
  logic [NUM_VOICES-1:0]      r_strike, w_strike_nxt;
  logic [NUM_VOICES-1:0]      w_hit;
  logic [NUM_VOICES-1:0]      w_free_oh;
  logic                       w_free_any;
  logic                       r_drop, w_drop_nxt;

`ifdef PS2DEC_SUSTAIN_EN
  logic [NUM_VOICES-1:0] r_pend, w_pend_nxt;
  logic                  r_sus;
  logic                  r_held_sp;
  logic                  w_sus_toggle;
  assign w_sus_toggle = w_do_make && (scan.scan_data == 8'h29) && !r_held_sp;
`endif

  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++)
      w_hit[i] = r_gate[i] && (r_note[i] == w_note_val);
  end

  // Lowest-index free voice as a one-hot vector.
  always_comb begin
    w_free_oh  = '0;
    w_free_any = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!r_gate[i] && !w_free_any) begin
        w_free_oh[i] = 1'b1;
        w_free_any   = 1'b1;
      end
    end
  end

  always_comb begin
    w_note_nxt   = r_note;
    w_gate_nxt   = r_gate;
    w_strike_nxt = '0;
    w_drop_nxt   = 1'b0;
`ifdef PS2DEC_SUSTAIN_EN
    w_pend_nxt   = r_pend;
`endif
    if (w_do_make && w_note_ok) begin
      if (|w_hit) begin
`ifdef PS2DEC_SUSTAIN_EN
        // A held-by-sustain voice is re-struck in place; a truly held one is a typematic repeat.
        w_strike_nxt = w_hit & r_pend;
        w_pend_nxt   = r_pend & ~w_hit;
`endif
      end else if (w_free_any) begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          if (w_free_oh[i]) begin
            w_note_nxt[i]   = w_note_val;
            w_gate_nxt[i]   = 1'b1;
            w_strike_nxt[i] = 1'b1;
          end
        end
      end else begin
        w_drop_nxt = 1'b1;
      end
    end
    if (w_do_break && w_note_ok) begin
`ifdef PS2DEC_SUSTAIN_EN
      if (r_sus) w_pend_nxt = r_pend | w_hit;
      else       w_gate_nxt = r_gate & ~w_hit;
`else
      w_gate_nxt = r_gate & ~w_hit;
`endif
    end
`ifdef PS2DEC_SUSTAIN_EN
    if (w_sus_toggle && r_sus) begin
      w_gate_nxt = w_gate_nxt & ~r_pend;
      w_pend_nxt = '0;
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_note   <= '0;
      r_gate   <= '0;
      r_strike <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_note   <= w_note_nxt;
      r_gate   <= w_gate_nxt;
      r_strike <= w_strike_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

`ifdef PS2DEC_SUSTAIN_EN
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_pend    <= '0;
      r_sus     <= 1'b0;
      r_held_sp <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_sus_toggle) r_sus <= ~r_sus;
      if (w_do_make && scan.scan_data == 8'h29)       r_held_sp <= 1'b1;
      else if (w_do_break && scan.scan_data == 8'h29) r_held_sp <= 1'b0;
    end
  end
  assign sustain_on = r_sus;
`else
  assign sustain_on = 1'b0;
`endif

  // ---------------------------------------------------------------- controls
  logic             r_held_dn, r_held_up, r_held_dec, r_held_inc;
  logic [OCT_W-1:0] r_octave;
  logic [2:0]       r_adsr;
  logic             r_inc, r_dec;
  logic             w_first_dn, w_first_up, w_first_dec, w_first_inc;

  assign w_first_dn  = w_do_make && w_key_dn  && !r_held_dn;
  assign w_first_up  = w_do_make && w_key_up  && !r_held_up;
  assign w_first_dec = w_do_make && w_key_dec && !r_held_dec;
  assign w_first_inc = w_do_make && w_key_inc && !r_held_inc;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_held_dn  <= 1'b0;
      r_held_up  <= 1'b0;
      r_held_dec <= 1'b0;
      r_held_inc <= 1'b0;
      r_octave   <= L_OCT_DEF;
      r_adsr     <= 3'd0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
    end else begin
      r_inc <= w_first_inc;
      r_dec <= w_first_dec;

      if (w_first_up && r_octave < L_OCT_MAX)      r_octave <= r_octave + 1'b1;
      else if (w_first_dn && r_octave > L_OCT_MIN) r_octave <= r_octave - 1'b1;

      if (w_do_make && w_key_dn)        r_held_dn <= 1'b1;
      else if (w_do_break && w_key_dn)  r_held_dn <= 1'b0;
      if (w_do_make && w_key_up)        r_held_up <= 1'b1;
      else if (w_do_break && w_key_up)  r_held_up <= 1'b0;
      if (w_do_make && w_key_dec)       r_held_dec <= 1'b1;
      else if (w_do_break && w_key_dec) r_held_dec <= 1'b0;
      if (w_do_make && w_key_inc)       r_held_inc <= 1'b1;
      else if (w_do_break && w_key_inc) r_held_inc <= 1'b0;

      if (w_do_make) begin
        case (scan.scan_data)
          8'h16:   r_adsr <= 3'd0;
          8'h1E:   r_adsr <= 3'd1;
          8'h26:   r_adsr <= 3'd2;
          8'h25:   r_adsr <= 3'd3;
          8'h2E:   r_adsr <= 3'd4;
          default: r_adsr <= r_adsr;
        endcase
      end
    end
  end

  assign voice_note   = r_note;
  assign voice_gate   = r_gate;
  assign voice_strike = r_strike;
  assign voice_drop   = r_drop;
  assign octave       = r_octave;
  assign adsr_sel     = r_adsr;
  assign param_inc    = r_inc;
  assign param_dec    = r_dec;

endmodule

// File: tb/tb_ps2_poly_key_decoder.sv
// Bench for ps2_poly_key_decoder: directed sequences with literal expectations,
// then randomized byte streams checked every cycle against a behavioural model.
// Define PS2DEC_SUSTAIN_EN to also exercise the sustain feature.
module tb_ps2_poly_key_decoder;
  localparam int NV = 4;

  logic              clk;
  logic              resetn;
  logic [4*NV-1:0]   voice_note;
  logic [NV-1:0]     voice_gate;
  logic [NV-1:0]     voice_strike;
  logic [2:0]        octave;
  logic [2:0]        adsr_sel;
  logic              param_inc, param_dec, voice_drop, sustain_on;

  ps2_poly_key_decoder_if bus ();

  ps2_poly_key_decoder #(
    .NUM_VOICES(NV), .OCT_W(3), .OCT_MIN(1), .OCT_MAX(6), .OCT_DEFAULT(4)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .scan(bus),
    .voice_note(voice_note), .voice_gate(voice_gate), .voice_strike(voice_strike),
    .octave(octave), .adsr_sel(adsr_sel), .param_inc(param_inc), .param_dec(param_dec),
    .voice_drop(voice_drop), .sustain_on(sustain_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ------------------------------------------------------------ model state
  logic [7:0] NOTE_CODES [12];
  int  m_note [NV];
  bit  m_gate [NV];
  bit  m_pend [NV];
  bit  m_held [256];
  bit  [NV-1:0] m_strike;
  int  m_oct, m_adsr;
  bit  m_inc, m_dec, m_drop, m_sus;
  bit  m_ext, m_brk;

  function automatic int note_of(input logic [7:0] b);
    note_of = -1;
    for (int k = 0; k < 12; k++) if (NOTE_CODES[k] == b) note_of = k;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NV; i++) begin m_note[i] = 0; m_gate[i] = 0; m_pend[i] = 0; end
    for (int i = 0; i < 256; i++) m_held[i] = 0;
    m_strike = '0; m_oct = 4; m_adsr = 0;
    m_inc = 0; m_dec = 0; m_drop = 0; m_sus = 0; m_ext = 0; m_brk = 0;
  endtask

  task automatic m_make(input logic [7:0] b);
    int n, hold, free;
    bit first;
    n = note_of(b);
    first = !m_held[b];
    if (n >= 0) begin
      hold = -1; free = -1;
      for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == n) hold = i;
      for (int i = NV - 1; i >= 0; i--) if (!m_gate[i]) free = i;
      if (hold >= 0) begin
        if (m_pend[hold]) begin m_pend[hold] = 0; m_strike[hold] = 1'b1; end
      end else if (free >= 0) begin
        m_note[free] = n; m_gate[free] = 1; m_strike[free] = 1'b1;
      end else m_drop = 1;
      return;
    end
    case (b)
      8'h1A: if (first && m_oct > 1) m_oct--;
      8'h22: if (first && m_oct < 6) m_oct++;
      8'h21: m_dec = first;
      8'h2A: m_inc = first;
      8'h16: m_adsr = 0;
      8'h1E: m_adsr = 1;
      8'h26: m_adsr = 2;
      8'h25: m_adsr = 3;
      8'h2E: m_adsr = 4;
`ifdef PS2DEC_SUSTAIN_EN
      8'h29: if (first) begin
        if (m_sus)
          for (int i = 0; i < NV; i++) if (m_pend[i]) begin m_gate[i] = 0; m_pend[i] = 0; end
        m_sus = !m_sus;
      end
`endif
      default: ;
    endcase
    if (b inside {8'h1A, 8'h22, 8'h21, 8'h2A, 8'h29}) m_held[b] = 1;
  endtask

  task automatic m_break(input logic [7:0] b);
    int n;
    n = note_of(b);
    m_held[b] = 0;
    if (n >= 0)
      for (int i = 0; i < NV; i++)
        if (m_gate[i] && m_note[i] == n) begin
          if (m_sus) m_pend[i] = 1; else m_gate[i] = 0;
        end
  endtask

  task automatic m_apply(input bit v, input logic [7:0] b);
    m_strike = '0; m_inc = 0; m_dec = 0; m_drop = 0;
    if (!v) return;
    if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else m_make(b);
    end else if (!m_ext && m_brk) begin
      if (b == 8'hE0) begin m_brk = 0; m_ext = 1; end
      else if (b != 8'hF0) begin m_break(b); m_brk = 0; end
    end else if (m_ext && !m_brk) begin
      if (b == 8'hF0) m_brk = 1; else m_ext = 0;
    end else begin
      m_ext = 0; m_brk = 0;
    end
  endtask

  // ------------------------------------------------------------ checking
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [4*NV-1:0] e_note;
    logic [NV-1:0]   e_gate;
    logic [3:0]      nib;
    for (int i = 0; i < NV; i++) begin
      nib = 4'(m_note[i]);
      e_note[i*4 +: 4] = nib;
      e_gate[i] = m_gate[i];
    end
    chk("voice_note", 64'(voice_note), 64'(e_note));
    chk("voice_gate", 64'(voice_gate), 64'(e_gate));
    chk("voice_strike", 64'(voice_strike), 64'(m_strike));
    chk("octave", 64'(octave), 64'(m_oct));
    chk("adsr_sel", 64'(adsr_sel), 64'(m_adsr));
    chk("param_inc", 64'(param_inc), 64'(m_inc));
    chk("param_dec", 64'(param_dec), 64'(m_dec));
    chk("voice_drop", 64'(voice_drop), 64'(m_drop));
    chk("sustain_on", 64'(sustain_on), 64'(m_sus));
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    bus.scan_valid = v;
    bus.scan_data  = b;
    m_apply(v, b);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic do_reset();
    bus.scan_valid = 1'b0;
    resetn = 1'b0;
    m_reset();
    @(negedge clk);
    compare_all();
    resetn = 1'b1;
  endtask

  logic [7:0] PICK [30];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] b;
    NOTE_CODES = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                   8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
    PICK = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35, 8'h33,
             8'h3C, 8'h3B, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h16, 8'h1E, 8'h26, 8'h25,
             8'h2E, 8'h29, 8'h29, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF, 8'hE0, 8'h1C};
    bus.scan_valid = 1'b0;
    bus.scan_data  = 8'h00;
    resetn = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    chk("rst_gate", 64'(voice_gate), 64'h0);
    chk("rst_octave", 64'(octave), 64'd4);
    chk("rst_adsr", 64'(adsr_sel), 64'd0);
    chk("rst_pulses", 64'({voice_strike, param_inc, param_dec, voice_drop}), 64'h0);
    resetn = 1'b1;
    step(1'b0, 8'h00);

    // typematic repeat, then break
    send(8'h1C); chk("tm_strike1", 64'(voice_strike), 64'h1); chk("tm_gate1", 64'(voice_gate), 64'h1);
    send(8'h1C); chk("tm_strike2", 64'(voice_strike), 64'h0);
    send(8'h1C); chk("tm_strike3", 64'(voice_strike), 64'h0);
    send(8'hF0); send(8'h1C); chk("tm_gate_brk", 64'(voice_gate), 64'h0);

    // voice allocation and drop
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
    chk("alloc_notes", 64'(voice_note), 64'h5420);
    chk("alloc_gates", 64'(voice_gate), 64'hF);
    send(8'h34); chk("alloc_drop", 64'(voice_drop), 64'h1);
    chk("alloc_nochange", 64'(voice_note), 64'h5420);
    send(8'hF0); send(8'h1B); chk("alloc_rel1", 64'(voice_gate), 64'hD);
    send(8'h34); chk("alloc_v1", 64'(voice_note), 64'h5470); chk("alloc_strk", 64'(voice_strike), 64'h2);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h34);
    send(8'hF0); send(8'h23); send(8'hF0); send(8'h2B);
    chk("alloc_clear", 64'(voice_gate), 64'h0);

    // octave saturation and held-key suppression
    send(8'h22); chk("oct_a", 64'(octave), 64'd5); send(8'hF0); send(8'h22);
    send(8'h22); chk("oct_b", 64'(octave), 64'd6); send(8'hF0); send(8'h22);
    send(8'h22); chk("oct_c", 64'(octave), 64'd6); send(8'hF0); send(8'h22);
    send(8'h22); chk("oct_d", 64'(octave), 64'd6); send(8'hF0); send(8'h22);
    send(8'h1A); send(8'h1A); send(8'h1A); chk("oct_held", 64'(octave), 64'd5);
    send(8'hF0); send(8'h1A);

    // adsr select, param pulse, extended bytes ignored
    send(8'h26); chk("adsr2", 64'(adsr_sel), 64'd2);
    send(8'h2A); chk("inc_pulse", 64'(param_inc), 64'h1);
    step(1'b0, 8'h00); chk("inc_one_cycle", 64'(param_inc), 64'h0);
    send(8'hF0); send(8'h2A);
    send(8'hE0); send(8'h2A); chk("ext_noinc", 64'(param_inc), 64'h0);
    send(8'hE0); send(8'hF0); send(8'h1C); chk("ext_brk_noop", 64'(voice_gate), 64'h0);
    send(8'h1C); chk("back_idle", 64'(voice_strike), 64'h1);
    send(8'hF0); send(8'h1C);

    // reset mid-break discards the prefix
    send(8'hF0);
    do_reset();
    send(8'h1C); chk("rst_mid_make", 64'(voice_gate), 64'h1);
    send(8'hF0); send(8'h1C);

`ifdef PS2DEC_SUSTAIN_EN
    send(8'h29); chk("sus_on", 64'(sustain_on), 64'h1); send(8'hF0); send(8'h29);
    send(8'h1C); send(8'hF0); send(8'h1C); chk("sus_hold", 64'(voice_gate), 64'h1);
    send(8'h1C); chk("sus_restrike", 64'(voice_strike), 64'h1);
    send(8'hF0); send(8'h1C);
    send(8'h29); chk("sus_off_gate", 64'(voice_gate), 64'h0); chk("sus_off", 64'(sustain_on), 64'h0);
    send(8'hF0); send(8'h29);
`endif

    // randomized streams
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 20)       step(1'b0, 8'($urandom));
      else if (r < 42)  send(8'hF0);
      else if (r < 45)  send(8'hE0);
      else if (r < 46)  do_reset();
      else if (r < 52)  send(8'($urandom));
      else begin
        b = PICK[$urandom_range(0, 29)];
        send(b);
      end
    end
    step(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
